in1536_out128: RTL and testbench
================================

# in1536_out128

Width down-converter for the data-route output side: takes 1536-bit AXI-Stream beats, each carrying 12 lanes of 128 bits plus a per-lane last vector, and serializes them onto a 128-bit AXI-Stream with tkeep/tlast for the DMA (d/e ports).
- It is the reverse of the 128→1536 up-converter on the input side. The 12-bit lane-last vector it consumes has the same format that converter produces, so a packet round-trips unchanged.
- Full throughput: one 128-bit beat per cycle while downstream is ready, with no bubbles between wide beats.

## Interface
Parameters:
- IN_WIDTH, 1536, input beat width.
- OUT_WIDTH, 128, output beat width. RATIO = IN_WIDTH/OUT_WIDTH = 12 and must be an integer.
- LCNT_W, 4, lane counter width, equal to clog2(RATIO).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- s_axis_tdata  in  IN_WIDTH  wide beat; lane k = bits [128k+127:128k].
- s_axis_tvalid  in  1  wide beat valid.
- s_axis_tready  out  1  wide beat accepted when tvalid&tready.
- s_axis_tlast  in  RATIO  bit k=1: lane k is the final lane of the packet.
- m_axis_tdata  out  OUT_WIDTH  current lane.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tkeep  out  16  constant 16'hffff.
- m_axis_tlast  out  1  packet end.

## Operation
Storage:
- Holding register hold_d[IN_WIDTH-1:0], holding vector hold_l[RATIO-1:0], flag full, lane counter lane[LCNT_W-1:0].
- States: EMPTY (full=0) and SEND (full=1).

Outputs:
- m_axis_tdata = hold_d[127:0]; m_axis_tlast = hold_l[0]; m_axis_tvalid = full.
- Define fin = full & m_axis_tready & (hold_l[0] | lane==RATIO-1).

Ready:
- s_axis_tready = ~rst & (~full | fin).

Per clock, in priority order:
- **Accept** (s_axis_tvalid & s_axis_tready): hold_d←s_axis_tdata, hold_l←s_axis_tlast, lane←0, full←1. This takes priority over the other cases, including when fin is true in the same cycle.
- **Finish without new input** (fin & ~accept): full←0, lane←0.
- **Shift** (full & m_axis_tready & ~fin): hold_d shifts right by OUT_WIDTH, hold_l shifts right by 1, lane←lane+1.
- **Stall** (full & ~m_axis_tready): all state holds.

Boundary rules:
- Early termination: a set hold_l bit at lane k<11 ends the wide beat after lane k. Lanes k+1..11 are discarded and never emitted.
- Multiple set bits in s_axis_tlast: only the lowest set bit matters.
- s_axis_tlast=0: all 12 lanes are emitted with m_axis_tlast=0, and the packet continues in the next wide beat.
- lane never exceeds RATIO-1, so there is no wrap-around beyond it.
- m_axis_tkeep is always 16'hffff. Partial lanes are not supported; upstream pads.

Reset:
- rst high clears full, lane, hold_l and hold_d to 0 asynchronously. Any in-flight wide beat is dropped.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 (forced while rst high), m_axis_tkeep=16'hffff.

## Timing
Latency:
- First output lane is valid the cycle after the input handshake (1 cycle).

Throughput:
- 12 output beats per full wide beat.
- When the next wide beat is presented with tvalid before fin, it is accepted in the fin cycle. Lane 0 of the new beat follows lane 11 of the previous one with no idle cycle.

Handshake rules:
- s_axis_tready depends combinationally on m_axis_tready and the registered state. There is no combinational path from s_axis_tvalid to m_axis_*.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast stay stable.
- m_axis_tvalid never deasserts without a handshake, except by reset.
- While in SEND, s_axis_tready is 0 except in the fin cycle.

## Test plan
- **Single beat:** lane k=32'h0000_00k0 replicated, s_axis_tlast=0, m_axis_tready=1 → 12 beats in lane order 0..11 on cycles 1..12, tlast=0 throughout, s_axis_tready=0 on cycles 1..11 and 1 on cycle 12.
- **Back-to-back:** two beats with s_axis_tvalid held, m_axis_tready=1 → 24 consecutive output beats with no gap; second beat accepted in the cycle lane 11 of the first handshakes.
- **Early termination:** s_axis_tlast=12'h010 → 5 beats (lanes 0..4), tlast=1 on lane 4, lanes 5..11 never appear; next beat accepted on the lane-4 handshake.
- **Full-length packet end:** s_axis_tlast=12'h800 → 12 beats, tlast=1 only on lane 11. A second case with s_axis_tlast=12'h00C → 3 beats, tlast on lane 2.
- **Backpressure:** random m_axis_tready (50%) over 100 beats → scoreboard matches the lane sequence exactly; data/tlast stable during every stall; no loss or duplication.
- **Reset mid-beat:** rst pulsed after lane 3 handshake → m_axis_tvalid=0 immediately (asynchronous); s_axis_tready=0 while rst high and 1 the first cycle after release; next beat restarts at lane 0 with no residue from the dropped beat.

Source files
------------

// File: rtl/in1536_out128.sv
// in1536_out128 -- 1536-bit to 128-bit AXI-Stream width down-converter.
//
// A wide beat carries 12 lanes of 128 bits (lane k = bits [128k+127:128k])
// and a 12-bit lane-last vector. The beat is captured whole, then emitted one
// lane per cycle, lowest lane first. The lowest set lane-last bit marks the
// final lane of the packet: it is sent with m_axis_tlast=1 and any higher lanes
// of that wide beat are discarded. The next wide beat is accepted in the same
// cycle the final lane handshakes, so consecutive beats stream with no bubble.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   s_axis_tdata   wide input beat (IN_WIDTH)
//   s_axis_tvalid  wide beat valid
//   s_axis_tready  wide beat ready (combinational on m_axis_tready and state)
//   s_axis_tlast   per-lane last vector (RATIO)
//   m_axis_tdata   current output lane (OUT_WIDTH)
//   m_axis_tvalid  output valid
//   m_axis_tready  downstream ready
//   m_axis_tkeep   always all ones
//   m_axis_tlast   packet end on this lane
module in1536_out128 #(
   parameter int IN_WIDTH  = 1536,
   parameter int OUT_WIDTH = 128,
   parameter int LCNT_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_WIDTH-1:0]   s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [IN_WIDTH/OUT_WIDTH-1:0] s_axis_tlast,
   output logic [OUT_WIDTH-1:0]  m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [15:0]           m_axis_tkeep,
   output logic                  m_axis_tlast
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam logic [LCNT_W-1:0] LAST_LANE = LCNT_W'(RATIO - 1);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      SEND  = 1'b1
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [IN_WIDTH-1:0]  hold_d_r;
   logic [IN_WIDTH-1:0]  hold_d_nxt_s;
   logic [RATIO-1:0]     hold_l_r;
   logic [RATIO-1:0]     hold_l_nxt_s;
   logic [LCNT_W-1:0]    lane_r;
   logic [LCNT_W-1:0]    lane_nxt_s;
   logic                 full_s;
   logic                 fin_s;
   logic                 accept_s;

   assign full_s = (state_r == SEND);

   // The current lane is the last one of this wide beat when its lane-last bit
   // is set or it is physically lane 11; fin is that lane handshaking.
   assign fin_s = full_s & m_axis_tready & (hold_l_r[0] | (lane_r == LAST_LANE));

   assign s_axis_tready = ~rst & (~full_s | fin_s);
   assign accept_s      = s_axis_tvalid & s_axis_tready;

   assign m_axis_tdata  = hold_d_r[OUT_WIDTH-1:0];
   assign m_axis_tlast  = hold_l_r[0];
   assign m_axis_tvalid = full_s;
   assign m_axis_tkeep  = 16'hffff;

   // Next-state: accept beats finish, finish beats shift, stall holds.
   always_comb begin
      state_nxt_s  = state_r;
      hold_d_nxt_s = hold_d_r;
      hold_l_nxt_s = hold_l_r;
      lane_nxt_s   = lane_r;
      if (accept_s) begin
         // A new beat may land in the same cycle the old one finishes.
         state_nxt_s  = SEND;
         hold_d_nxt_s = s_axis_tdata;
         hold_l_nxt_s = s_axis_tlast;
         lane_nxt_s   = {LCNT_W{1'b0}};
      end else if (fin_s) begin
         state_nxt_s = EMPTY;
         lane_nxt_s  = {LCNT_W{1'b0}};
      end else if (full_s && m_axis_tready) begin
         hold_d_nxt_s = hold_d_r >> OUT_WIDTH;
         hold_l_nxt_s = hold_l_r >> 1;
         lane_nxt_s   = lane_r + LCNT_W'(1);
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and holding registers; reset drops any in-flight beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= EMPTY;
         hold_d_r <= {IN_WIDTH{1'b0}};
         hold_l_r <= {RATIO{1'b0}};
         lane_r   <= {LCNT_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         hold_d_r <= hold_d_nxt_s;
         hold_l_r <= hold_l_nxt_s;
         lane_r   <= lane_nxt_s;
      end
   end

endmodule

// File: tb/tb_in1536_out128.sv
// tb_in1536_out128 -- directed and randomized bench for in1536_out128.
// Reference model: every accepted wide beat is expanded into the list of
// lanes it must produce (up to and including the lowest set lane-last bit, or
// all 12), queued in order. Each cycle the DUT output must show the queue head
// whenever the queue is non-empty, and s_axis_tready must be high exactly when
// nothing is pending or the head lane ends its wide beat and is being taken.
module tb_in1536_out128;

   logic          clk = 1'b0;
   logic          rst;
   logic [1535:0] s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic [11:0]   s_tlast;
   logic [127:0]  m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic [15:0]   m_tkeep;
   logic          m_tlast;

   in1536_out128 dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] d;
      logic         l;
      logic         eob;
   } ent_t;

   ent_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   emitted  = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void push_beat(input logic [1535:0] d, input logic [11:0] l);
      ent_t e;
      for (int k = 0; k < 12; k++) begin
         e.d   = d[128*k +: 128];
         e.l   = l[k];
         e.eob = l[k] || (k == 11);
         q.push_back(e);
         if (e.eob) break;
      end
   endfunction

   function automatic logic [1535:0] rand_beat();
      logic [1535:0] d;
      for (int w = 0; w < 48; w++) d[32*w +: 32] = $urandom();
      return d;
   endfunction

   // One clock: drive at negedge, check settled outputs, update model.
   task automatic step(input logic sv, input logic [1535:0] sd, input logic [11:0] sl,
                       input logic mr, output logic acc);
      logic exp_rdy;
      @(negedge clk);
      s_tvalid = sv;
      s_tdata  = sd;
      s_tlast  = sl;
      m_tready = mr;
      #1;
      chk("m_tvalid", 128'(m_tvalid), 128'(q.size() != 0));
      chk("m_tkeep", 128'(m_tkeep), 128'(16'hffff));
      if (q.size() == 0) exp_rdy = 1'b1;
      else exp_rdy = mr && q[0].eob;
      chk("s_tready", 128'(s_tready), 128'(exp_rdy));
      if (q.size() != 0) begin
         chk("m_tdata", m_tdata, q[0].d);
         chk("m_tlast", 128'(m_tlast), 128'(q[0].l));
         if (mr) begin
            void'(q.pop_front());
            emitted++;
         end
      end
      acc = sv && s_tready;
      if (acc) push_beat(sd, sl);
   endtask

   task automatic drain(input int max, input int ready_pct);
      logic acc;
      int n = 0;
      while (q.size() != 0 && n < max) begin
         step(1'b0, '0, '0, ($urandom_range(0, 99) < ready_pct), acc);
         n++;
      end
      chk("drain_timeout", 128'(q.size()), 128'(0));
      step(1'b0, '0, '0, 1'b1, acc);
   endtask

   // Present beat with tvalid held until taken; returns cycles waited.
   task automatic offer(input logic [1535:0] d, input logic [11:0] l, output int waited);
      logic acc;
      waited = 0;
      acc    = 1'b0;
      while (!acc && waited < 40) begin
         step(1'b1, d, l, 1'b1, acc);
         if (!acc) waited++;
      end
      chk("offer_timeout", 128'(acc), 128'(1));
   endtask

   initial begin
      logic [1535:0] pat;
      logic [1535:0] d;
      logic [11:0]   l;
      logic          acc;
      int            waited;
      int            accepted;
      int            n;

      rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0;
      #2;
      chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
      chk("rst_m_tlast", 128'(m_tlast), 128'(0));
      chk("rst_m_tdata", m_tdata, 128'(0));
      chk("rst_s_tready", 128'(s_tready), 128'(0));
      chk("rst_m_tkeep", 128'(m_tkeep), 128'(16'hffff));
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Single beat, lane k = 32'h0000_00k0 replicated, no packet end.
      for (int k = 0; k < 12; k++) pat[128*k +: 128] = {4{32'(k << 4)}};
      emitted = 0;
      step(1'b1, pat, 12'h000, 1'b1, acc);
      chk("single_acc", 128'(acc), 128'(1));
      drain(50, 100);
      chk("single_count", 128'(emitted), 128'(12));

      // Back-to-back: second beat accepted on lane 11 handshake of the first.
      emitted = 0;
      offer(rand_beat(), 12'h000, waited);
      offer(rand_beat(), 12'h000, waited);
      chk("b2b_wait", 128'(waited), 128'(11));
      drain(50, 100);
      chk("b2b_count", 128'(emitted), 128'(24));

      // Early termination on lane 4, then full-length end on lane 11.
      emitted = 0;
      offer(rand_beat(), 12'h010, waited);
      offer(rand_beat(), 12'h800, waited);
      chk("early_wait", 128'(waited), 128'(4));
      drain(50, 100);
      chk("early_count", 128'(emitted), 128'(17));

      // Lowest of several set bits ends the beat after lane 2.
      emitted = 0;
      offer(rand_beat(), 12'h00C, waited);
      offer(rand_beat(), 12'h001, waited);
      chk("multi_wait", 128'(waited), 128'(2));
      drain(50, 100);
      chk("multi_count", 128'(emitted), 128'(4));

      // Randomized traffic with 50% downstream backpressure.
      accepted = 0;
      n = 0;
      d = rand_beat();
      l = 12'h000;
      while (accepted < 100 && n < 5000) begin
         step($urandom_range(0, 3) != 0, d, l, $urandom_range(0, 1) == 1, acc);
         if (acc) begin
            accepted++;
            d = rand_beat();
            if ($urandom_range(0, 2) == 0) l = 12'h000;
            else l = 12'($urandom());
         end
         n++;
      end
      chk("rand_accepted", 128'(accepted), 128'(100));
      drain(2000, 50);

      // Reset after lane 3 handshake drops the beat.
      step(1'b1, rand_beat(), 12'h000, 1'b1, acc);
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, acc);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_m_tvalid", 128'(m_tvalid), 128'(0));
      chk("mid_rst_s_tready", 128'(s_tready), 128'(0));
      chk("mid_rst_m_tdata", m_tdata, 128'(0));
      q.delete();
      @(negedge clk);
      #1;
      chk("mid_rst_hold_tready", 128'(s_tready), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_s_tready", 128'(s_tready), 128'(1));
      emitted = 0;
      step(1'b1, rand_beat(), 12'h000, 1'b1, acc);
      chk("post_rst_acc", 128'(acc), 128'(1));
      drain(50, 100);
      chk("post_rst_count", 128'(emitted), 128'(12));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
